disp_scan_ctrl: RTL

Sequencer for the 4-digit seven-segment scan multiplexer. Generates the digit-select counter at a programmable rate. Holds a double-buffered frame of digit data, per-digit points and per-digit blank enables. Updates commit only at frame boundaries, so a frame never shows mixed old and new digits. Adds per-digit blinking; outputs feed the mux directly.

---
 rtl/disp_scan_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/disp_scan_ctrl.sv
// Purpose: scan sequencer for a 4-digit seven-segment mux with a double-buffered frame, blink and optional LZ blanking.
// Latency: an accepted update becomes visible at the next frame boundary, at most 4*SCAN_DIV cycles after transfer.
// Backpressure: upd_ready drops while an update is pending and rises again on the cycle after it commits.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   upd_valid / upd_ready    update handshake into the one-deep pending buffer
//   upd_hexs/point/les/blink update payload: 4 hex digits ([3:0] = digit 0), points, blank and blink enables
//   Scan                     digit select to the mux
//   Hexs, Point, Les         active digit data, points and effective blank enables
//   frame_done               one-cycle pulse on the cycle after the last slot of a frame ends
// Build option: define DISP_LZ_BLANK_EN to add leading-zero blanking of digits 3..1.
module disp_scan_ctrl #(
    parameter int SCAN_DIV     = 100000,
    parameter int DIV_W        = 17,
    parameter int BLINK_FRAMES = 250,
    parameter int BLINK_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_hexs,
    input  logic [3:0]  upd_point,
    input  logic [3:0]  upd_les,
    input  logic [3:0]  upd_blink,
    output logic [1:0]  Scan,
    output logic [15:0] Hexs,
    output logic [3:0]  Point,
    output logic [3:0]  Les,
    output logic        frame_done
);

    logic [DIV_W-1:0]   r_div_cnt;
    logic [1:0]         r_scan;
    logic               r_frame_done;

    logic               r_pend_full;
    logic [15:0]        r_pend_hexs;
    logic [3:0]         r_pend_point;
    logic [3:0]         r_pend_les;
    logic [3:0]         r_pend_blink;

    logic [15:0]        r_act_hexs;
    logic [3:0]         r_act_point;
    logic [3:0]         r_act_les;
    logic [3:0]         r_act_blink;

    logic [BLINK_W-1:0] r_frame_cnt;
    logic               r_blink_phase;

    logic               w_tick;
    logic               w_frame_end;
    logic               w_xfer;
    logic               w_commit;
    logic [3:0]         w_les_blink;

    assign w_tick      = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
    assign w_frame_end = w_tick && (r_scan == 2'd3);
    assign upd_ready   = !r_pend_full;
    assign w_xfer      = upd_valid && !r_pend_full;
    // Commit and transfer are mutually exclusive: commit needs a full buffer, transfer an empty one.
    // A transfer landing on frame_end therefore waits for the following boundary.
    assign w_commit    = w_frame_end && r_pend_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt     <= '0;
            r_scan        <= 2'd0;
            r_frame_done  <= 1'b0;
            r_pend_full   <= 1'b0;
            r_pend_hexs   <= 16'h0000;
            r_pend_point  <= 4'h0;
            r_pend_les    <= 4'hF;
            r_pend_blink  <= 4'h0;
            r_act_hexs    <= 16'h0000;
            r_act_point   <= 4'h0;
            r_act_les     <= 4'hF;
            r_act_blink   <= 4'h0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_div_cnt    <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
            if (w_tick) begin
                r_scan <= r_scan + 2'd1;
            end
            r_frame_done <= w_frame_end;

            if (w_commit) begin
                r_act_hexs  <= r_pend_hexs;
                r_act_point <= r_pend_point;
                r_act_les   <= r_pend_les;
                r_act_blink <= r_pend_blink;
                r_pend_full <= 1'b0;
            end else if (w_xfer) begin
                r_pend_hexs  <= upd_hexs;
                r_pend_point <= upd_point;
                r_pend_les   <= upd_les;
                r_pend_blink <= upd_blink;
                r_pend_full  <= 1'b1;
            end

            // Blink phase free-runs on frame count; commits deliberately leave it alone.
            if (w_frame_end) begin
                if (r_frame_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + BLINK_W'(1);
                end
            end
        end
    end

    assign Scan        = r_scan;
    assign Hexs        = r_act_hexs;
    assign Point       = r_act_point;
    assign frame_done  = r_frame_done;
    assign w_les_blink = r_act_les | (r_act_blink & {4{r_blink_phase}});

`ifdef DISP_LZ_BLANK_EN
    logic       w_z3;
    logic       w_z2;
    logic       w_z1;
    logic [3:0] w_lz;

    assign w_z3 = (r_act_hexs[15:12] == 4'h0);
    assign w_z2 = (r_act_hexs[11:8]  == 4'h0);
    assign w_z1 = (r_act_hexs[7:4]   == 4'h0);
    // A digit is a leading zero only if it and every more-significant digit are zero; digit 0 always shows.
    assign w_lz = {w_z3, w_z3 & w_z2, w_z3 & w_z2 & w_z1, 1'b0};
    assign Les  = w_les_blink | w_lz;
`else
    assign Les  = w_les_blink;
`endif

endmodule
